// File: rtl/prv_trap_ctrl_pkg.sv
// Package: prv_trap_ctrl_pkg
// Purpose: shared encodings for the machine-mode trap controller. It holds the
//   exception and interrupt cause codes, the RISC-MGMT custom cause base, the
//   controller state enum and the priority-encoder result struct.
// Ports: none (package).
package prv_trap_ctrl_pkg;

  typedef enum logic [4:0] {
    EXC_INSN_MAL    = 5'd0,
    EXC_INSN_FAULT  = 5'd1,
    EXC_ILLEGAL     = 5'd2,
    EXC_BREAKPOINT  = 5'd3,
    EXC_LOAD_MAL    = 5'd4,
    EXC_LOAD_FAULT  = 5'd5,
    EXC_STORE_MAL   = 5'd6,
    EXC_STORE_FAULT = 5'd7,
    EXC_ECALL_M     = 5'd11
  } ex_code_t;

  typedef enum logic [4:0] {
    INT_M_SOFT  = 5'd3,
    INT_M_TIMER = 5'd7,
    INT_M_EXT   = 5'd11
  } int_code_t;

  localparam int RMGMT_BASE_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_int;
    logic [4:0] code;
    logic       use_badaddr;
  } trap_sel_t;

endpackage

// File: rtl/prv_trap_ctrl_if.sv
// Interface: prv_trap_ctrl_if
// Purpose: bundles the hazard-unit exception protocol, the interrupt/CSR inputs
//   and the CSR update strobes exchanged with the trap controller.
// Modports:
//   master - hazard unit / CSR file side (drives strobes, epc, badaddr, CSR state)
//   slave  - trap controller side (drives priv_pc, insert_pc, intr, CSR writes)
interface prv_trap_ctrl_if #(parameter int RMGMT_CAUSE_W = 2) ();

  logic                     fault_insn, mal_insn, illegal_insn;
  logic                     fault_l, mal_l, fault_s, mal_s;
  logic                     breakpoint, env_m;
  logic                     ex_rmgmt;
  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause;
  logic                     ret;
  logic                     pipe_clear;
  logic [31:0]              epc;
  logic [31:0]              badaddr;
  logic                     timer_int, soft_int, ext_int;
  logic                     mtie, msie, meie;
  logic                     mstatus_mie;
  logic [31:0]              mtvec;
  logic [31:0]              mepc_r;

  logic [31:0]              priv_pc;
  logic                     insert_pc;
  logic                     intr;
  logic                     mcause_we, mepc_we, mtval_we;
  logic [31:0]              mcause_wdata, mepc_wdata, mtval_wdata;
  logic                     mstatus_push, mstatus_pop;

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ex_rmgmt, ex_rmgmt_cause, ret, pipe_clear, epc,
           badaddr, timer_int, soft_int, ext_int, mtie, msie, meie, mstatus_mie,
           mtvec, mepc_r,
    input  priv_pc, insert_pc, intr, mcause_we, mepc_we, mtval_we,
           mcause_wdata, mepc_wdata, mtval_wdata, mstatus_push, mstatus_pop
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ex_rmgmt, ex_rmgmt_cause, ret, pipe_clear, epc,
           badaddr, timer_int, soft_int, ext_int, mtie, msie, meie, mstatus_mie,
           mtvec, mepc_r,
    output priv_pc, insert_pc, intr, mcause_we, mepc_we, mtval_we,
           mcause_wdata, mepc_wdata, mtval_wdata, mstatus_push, mstatus_pop
  );

endinterface

// File: rtl/prv_trap_ctrl_prio.sv
// Module: prv_cause_prio
// Purpose: combinational trap-cause priority encoder. Exceptions always win over
//   interrupts; the interrupt inputs arrive already enabled and gated.
// Ports:
//   exception strobes (9) + ex_rmgmt/ex_rmgmt_cause  in
//   int_ext, int_soft, int_timer                      in  takeable interrupts
//   sel                                               out {valid,is_int,code,use_badaddr}
module prv_cause_prio
  import prv_trap_ctrl_pkg::*;
#(
  parameter int RMGMT_CAUSE_W = 2,
  parameter int RMGMT_BASE    = RMGMT_BASE_DEF
) (
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     fault_l,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     mal_s,
  input  logic                     breakpoint,
  input  logic                     env_m,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     int_ext,
  input  logic                     int_soft,
  input  logic                     int_timer,
  output trap_sel_t                sel
);

  logic [4:0] rmgmt_code;
  assign rmgmt_code = 5'(RMGMT_BASE + 32'(ex_rmgmt_cause));

  always_comb begin
    sel = '0;
    sel.valid = 1'b1;
    if (breakpoint)        sel.code = EXC_BREAKPOINT;
    else if (fault_insn) begin
      sel.code = EXC_INSN_FAULT;  sel.use_badaddr = 1'b1;
    end else if (mal_insn) begin
      sel.code = EXC_INSN_MAL;    sel.use_badaddr = 1'b1;
    end else if (illegal_insn) sel.code = EXC_ILLEGAL;
    else if (env_m)        sel.code = EXC_ECALL_M;
    else if (mal_s) begin
      sel.code = EXC_STORE_MAL;   sel.use_badaddr = 1'b1;
    end else if (mal_l) begin
      sel.code = EXC_LOAD_MAL;    sel.use_badaddr = 1'b1;
    end else if (fault_s) begin
      sel.code = EXC_STORE_FAULT; sel.use_badaddr = 1'b1;
    end else if (fault_l) begin
      sel.code = EXC_LOAD_FAULT;  sel.use_badaddr = 1'b1;
    end else if (ex_rmgmt) sel.code = rmgmt_code;
    else if (int_ext) begin
      sel.code = INT_M_EXT;   sel.is_int = 1'b1;
    end else if (int_soft) begin
      sel.code = INT_M_SOFT;  sel.is_int = 1'b1;
    end else if (int_timer) begin
      sel.code = INT_M_TIMER; sel.is_int = 1'b1;
    end else sel.valid = 1'b0;
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Module: prv_trap_ctrl
// Purpose: machine-mode trap sequencer. Takes exception/ret/pipe_clear strobes
//   from the hazard unit, arbitrates them against pending interrupts, then
//   issues a one-cycle redirect plus CSR update strobes for trap entry or mret.
// Ports:
//   clk, rst  in   clock, asynchronous active-high reset
//   bus       slave modport of prv_trap_ctrl_if (protocol, CSR inputs/outputs)
//
// state   | meaning
// IDLE    | waiting; arbitrates exception > interrupt > ret
// TRAP    | one cycle: redirect to trap vector, write mcause/mepc/mtval, push mstatus
// RET     | one cycle: redirect to mepc, pop mstatus
module prv_trap_ctrl
  import prv_trap_ctrl_pkg::*;
#(
  parameter int RMGMT_CAUSE_W = 2,
  parameter bit VECTORED_EN   = 1'b1,
  parameter int RMGMT_BASE    = RMGMT_BASE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  prv_trap_ctrl_if.slave bus
);

  trap_state_t state, state_nxt;
  trap_sel_t   sel;

  logic        idle;
  logic        int_any;
  logic        int_take;
  logic [31:0] vec_base;
  logic [31:0] trap_pc;
  logic [31:0] pc_q, cause_q, epc_q, tval_q;

  assign idle     = (state == ST_IDLE);
  assign int_any  = bus.mstatus_mie &
                    |{bus.ext_int & bus.meie, bus.soft_int & bus.msie, bus.timer_int & bus.mtie};
  // Interrupts are only taken once the pipeline has drained.
  assign int_take = idle & bus.mstatus_mie & bus.pipe_clear;

  prv_cause_prio #(
    .RMGMT_CAUSE_W (RMGMT_CAUSE_W),
    .RMGMT_BASE    (RMGMT_BASE)
  ) u_prio (
    .fault_insn     (bus.fault_insn),
    .mal_insn       (bus.mal_insn),
    .illegal_insn   (bus.illegal_insn),
    .fault_l        (bus.fault_l),
    .mal_l          (bus.mal_l),
    .fault_s        (bus.fault_s),
    .mal_s          (bus.mal_s),
    .breakpoint     (bus.breakpoint),
    .env_m          (bus.env_m),
    .ex_rmgmt       (bus.ex_rmgmt),
    .ex_rmgmt_cause (bus.ex_rmgmt_cause),
    .int_ext        (int_take & bus.ext_int & bus.meie),
    .int_soft       (int_take & bus.soft_int & bus.msie),
    .int_timer      (int_take & bus.timer_int & bus.mtie),
    .sel            (sel)
  );

  // Vectored mode only for interrupts with MODE==1; MODE 2/3 fall back to direct.
  assign vec_base = {bus.mtvec[31:2], 2'b00};
  assign trap_pc  = (VECTORED_EN && sel.is_int && bus.mtvec[1:0] == 2'b01)
                    ? vec_base + {25'd0, sel.code, 2'b00}
                    : vec_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (idle) begin
      if (sel.valid)    state_nxt = ST_TRAP;
      else if (bus.ret) state_nxt = ST_RET;
    end
  end

  // Capture everything the TRAP/RET cycle presents on the arbitration edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else if (idle) begin
      if (sel.valid) begin
        pc_q    <= trap_pc;
        cause_q <= {sel.is_int, 26'd0, sel.code};
        epc_q   <= bus.epc;
        tval_q  <= sel.use_badaddr ? bus.badaddr : 32'd0;
      end else if (bus.ret) begin
        pc_q    <= bus.mepc_r;
      end
    end
  end

  // Outputs are decoded from the registered state so they drop with async reset.
  always_comb begin
    bus.intr         = idle & int_any;
    bus.insert_pc    = 1'b0;
    bus.priv_pc      = '0;
    bus.mcause_we    = 1'b0;
    bus.mepc_we      = 1'b0;
    bus.mtval_we     = 1'b0;
    bus.mcause_wdata = '0;
    bus.mepc_wdata   = '0;
    bus.mtval_wdata  = '0;
    bus.mstatus_push = 1'b0;
    bus.mstatus_pop  = 1'b0;
    case (state)
      ST_TRAP: begin
        bus.insert_pc    = 1'b1;
        bus.priv_pc      = pc_q;
        bus.mcause_we    = 1'b1;
        bus.mepc_we      = 1'b1;
        bus.mtval_we     = 1'b1;
        bus.mcause_wdata = cause_q;
        bus.mepc_wdata   = epc_q;
        bus.mtval_wdata  = tval_q;
        bus.mstatus_push = 1'b1;
      end
      ST_RET: begin
        bus.insert_pc    = 1'b1;
        bus.priv_pc      = pc_q;
        bus.mstatus_pop  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
module tb_prv_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  prv_trap_ctrl_if #(.RMGMT_CAUSE_W(2)) bus ();

  prv_trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bus.fault_insn = 0; bus.mal_insn = 0; bus.illegal_insn = 0;
    bus.fault_l = 0; bus.mal_l = 0; bus.fault_s = 0; bus.mal_s = 0;
    bus.breakpoint = 0; bus.env_m = 0; bus.ex_rmgmt = 0; bus.ex_rmgmt_cause = 0;
    bus.ret = 0; bus.pipe_clear = 0;
  endtask

  task automatic clear_int();
    bus.timer_int = 0; bus.soft_int = 0; bus.ext_int = 0;
    bus.mtie = 0; bus.msie = 0; bus.meie = 0; bus.mstatus_mie = 0;
  endtask

  // Checks a full TRAP-cycle output set.
  task automatic chk_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] mepc, input logic [31:0] tval);
    chk({tag, ".insert_pc"}, 32'(bus.insert_pc), 32'd1);
    chk({tag, ".priv_pc"},   bus.priv_pc, pc);
    chk({tag, ".we"},        {29'd0, bus.mcause_we, bus.mepc_we, bus.mtval_we}, 32'd7);
    chk({tag, ".mcause"},    bus.mcause_wdata, cause);
    chk({tag, ".mepc"},      bus.mepc_wdata, mepc);
    chk({tag, ".mtval"},     bus.mtval_wdata, tval);
    chk({tag, ".push_pop"},  {30'd0, bus.mstatus_push, bus.mstatus_pop}, 32'd2);
    chk({tag, ".intr"},      32'(bus.intr), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".insert_pc"}, 32'(bus.insert_pc), 32'd0);
    chk({tag, ".strobes"},
        {27'd0, bus.mcause_we, bus.mepc_we, bus.mtval_we, bus.mstatus_push, bus.mstatus_pop},
        32'd0);
    chk({tag, ".priv_pc"}, bus.priv_pc, 32'd0);
  endtask

  initial begin
    clear_ex();
    clear_int();
    bus.epc = 0; bus.badaddr = 0; bus.mtvec = 0; bus.mepc_r = 0;

    #12;
    chk_quiet("reset");
    chk("reset.intr", 32'(bus.intr), 32'd0);
    step();
    rst = 0;

    // Load misaligned, direct vector.
    bus.mal_l = 1; bus.epc = 32'h100; bus.badaddr = 32'h203; bus.mtvec = 32'h800;
    step();
    clear_ex();
    chk_trap("mal_l", 32'h800, 32'd4, 32'h100, 32'h203);
    // Exception during TRAP is ignored; strobes last one cycle.
    bus.env_m = 1;
    step();
    chk_quiet("mal_l.after");
    clear_ex();
    step();

    // Breakpoint beats illegal; mtval forced to 0.
    bus.illegal_insn = 1; bus.breakpoint = 1; bus.epc = 32'h204; bus.badaddr = 32'h55;
    step();
    clear_ex();
    chk_trap("bkpt", 32'h800, 32'd3, 32'h204, 32'd0);
    step();
    chk_quiet("bkpt.after");

    // External interrupt, vectored.
    bus.mtvec = 32'h801; bus.ext_int = 1; bus.meie = 1; bus.mstatus_mie = 1; bus.epc = 32'h300;
    #1;
    chk("ext.intr", 32'(bus.intr), 32'd1);
    step();
    chk_quiet("ext.no_clear");
    bus.pipe_clear = 1;
    step();
    bus.pipe_clear = 0;
    chk_trap("ext", 32'h82C, 32'h8000000B, 32'h300, 32'd0);
    clear_int();
    step();
    chk_quiet("ext.after");

    // Exceptions use the base even when vectored.
    bus.illegal_insn = 1; bus.epc = 32'h310;
    step();
    clear_ex();
    chk_trap("illegal.vec", 32'h800, 32'd2, 32'h310, 32'd0);
    step();

    // MODE==2 treated as direct for interrupts.
    bus.mtvec = 32'h802; bus.soft_int = 1; bus.msie = 1; bus.mstatus_mie = 1; bus.pipe_clear = 1;
    bus.epc = 32'h320;
    step();
    clear_ex(); clear_int();
    chk_trap("soft.mode2", 32'h800, 32'h80000003, 32'h320, 32'd0);
    step();

    // Masked timer never fires.
    bus.timer_int = 1; bus.mtie = 0; bus.mstatus_mie = 1; bus.pipe_clear = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("timer_masked.intr", 32'(bus.intr), 32'd0);
      chk("timer_masked.insert_pc", 32'(bus.insert_pc), 32'd0);
    end

    // Exception beats interrupt: enabled timer + store fault.
    bus.mtie = 1; bus.mtvec = 32'h801; bus.fault_s = 1; bus.badaddr = 32'hABC; bus.epc = 32'h330;
    step();
    clear_ex();
    chk_trap("fault_s.vs_int", 32'h800, 32'd7, 32'h330, 32'hABC);
    step();
    // Timer still pending; now taken, vectored to base+28.
    bus.pipe_clear = 1;
    step();
    clear_ex(); clear_int();
    chk_trap("timer", 32'h81C, 32'h80000007, 32'h330, 32'd0);
    step();

    // Interrupt beats ret; ext beats soft and timer; vector address wraps.
    bus.mtvec = 32'hFFFF_FFFD;
    bus.ext_int = 1; bus.soft_int = 1; bus.timer_int = 1;
    bus.meie = 1; bus.msie = 1; bus.mtie = 1; bus.mstatus_mie = 1;
    bus.pipe_clear = 1; bus.ret = 1; bus.mepc_r = 32'h4A0; bus.epc = 32'h340;
    step();
    clear_ex(); clear_int();
    chk_trap("int_vs_ret", 32'h0000_0028, 32'h8000000B, 32'h340, 32'd0);
    step();

    // mret.
    bus.ret = 1; bus.mepc_r = 32'h4A0;
    step();
    clear_ex();
    bus.mepc_r = 32'h999;
    chk("ret.insert_pc", 32'(bus.insert_pc), 32'd1);
    chk("ret.priv_pc", bus.priv_pc, 32'h4A0);
    chk("ret.pop_push", {30'd0, bus.mstatus_pop, bus.mstatus_push}, 32'd2);
    chk("ret.we", {29'd0, bus.mcause_we, bus.mepc_we, bus.mtval_we}, 32'd0);
    step();
    chk_quiet("ret.after");

    // RISC-MGMT extension 2 -> 26; misaligned fetch beats it.
    bus.ex_rmgmt = 1; bus.ex_rmgmt_cause = 2'd2; bus.badaddr = 32'h77; bus.epc = 32'h350;
    bus.mtvec = 32'h1000;
    step();
    clear_ex();
    chk_trap("rmgmt", 32'h1000, 32'd26, 32'h350, 32'd0);
    step();
    bus.ex_rmgmt = 1; bus.mal_insn = 1; bus.badaddr = 32'h352;
    step();
    clear_ex();
    chk_trap("mal_insn", 32'h1000, 32'd0, 32'h350, 32'h352);
    step();

    // Reset during TRAP drops outputs immediately.
    bus.env_m = 1; bus.epc = 32'h360;
    step();
    clear_ex();
    chk("rst_mid.insert_pc", 32'(bus.insert_pc), 32'd1);
    rst = 1;
    #1;
    chk_quiet("rst_mid");
    step();
    chk_quiet("rst_mid.held");
    rst = 0;
    step();
    chk_quiet("rst_mid.release");
    bus.env_m = 1; bus.epc = 32'h370; bus.badaddr = 32'h44;
    step();
    clear_ex();
    chk_trap("env_m", 32'h1000, 32'd11, 32'h370, 32'd0);
    step();
    chk_quiet("env_m.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
